// File: rtl/sz_fp_pkg.sv
// Shared types and helpers for the SZ floating-point compare path:
// relation codes, per-operand classification and the sign/mode resolver.
package sz_fp_pkg;

  localparam int SP_EXP_W  = 8;
  localparam int SP_MAN_W  = 23;
  localparam int DP_EXP_W  = 11;
  localparam int DP_MAN_W  = 52;
  localparam int MAG_MAX_W = DP_EXP_W + DP_MAN_W;

  typedef enum logic [2:0] {
    CMP_LT   = 3'd0,
    CMP_LE   = 3'd1,
    CMP_EQ   = 3'd2,
    CMP_GE   = 3'd3,
    CMP_GT   = 3'd4,
    CMP_NE   = 3'd5,
    CMP_UN   = 3'd6,
    CMP_RSVD = 3'd7
  } cmp_mode_e;

  // Magnitude is {exp,man} zero-extended to the widest supported format.
  typedef struct packed {
    logic                 sign;
    logic                 nan;
    logic                 zero;
    logic [MAG_MAX_W-1:0] mag;
  } fp_class_t;

  typedef struct packed {
    logic      sign_a;
    logic      sign_b;
    logic      any_nan;
    logic      both_zero;
    logic      mag_lt;
    logic      mag_gt;
    cmp_mode_e mode;
  } cmp_s1_t;

  typedef struct packed {
    logic result;
    logic lt;
    logic eq;
    logic un;
  } cmp_flags_t;

  function automatic cmp_flags_t cmp_resolve(input cmp_s1_t s);
    cmp_flags_t f;
    logic       lt;
    logic       eq;
    lt = 1'b0;
    eq = 1'b0;
    if (s.any_nan) begin
      lt = 1'b0;
      eq = 1'b0;
    end else if (s.both_zero) begin
      lt = 1'b0;
      eq = 1'b1;
    end else if (s.sign_a != s.sign_b) begin
      lt = s.sign_a;
      eq = 1'b0;
    end else if (!s.sign_a) begin
      lt = s.mag_lt;
      eq = !s.mag_lt && !s.mag_gt;
    end else begin
      // Both negative: the larger magnitude is the smaller value.
      lt = s.mag_gt;
      eq = !s.mag_lt && !s.mag_gt;
    end
    f.lt = lt;
    f.eq = eq;
    f.un = s.any_nan;
    case (s.mode)
      CMP_LT:  f.result = lt;
      CMP_LE:  f.result = lt || eq;
      CMP_EQ:  f.result = eq;
      CMP_GE:  f.result = (!lt && !eq && !s.any_nan) || eq;
      CMP_GT:  f.result = !lt && !eq && !s.any_nan;
      CMP_NE:  f.result = !eq;
      CMP_UN:  f.result = s.any_nan;
      default: f.result = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand classifier: sign, NaN, zero and
// the unsigned {exp,man} magnitude used for ordering.
module fp_classify
  import sz_fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output fp_class_t            cls_o
);

  logic [EXP_W-1:0] exp_s;
  logic [MAN_W-1:0] man_s;

  assign exp_s = op_i[MAN_W +: EXP_W];
  assign man_s = op_i[MAN_W-1:0];

  always_comb begin
    cls_o.sign = op_i[EXP_W+MAN_W];
    cls_o.nan  = (&exp_s) && (|man_s);
    cls_o.zero = ~|{exp_s, man_s};
    cls_o.mag  = MAG_MAX_W'(op_i[EXP_W+MAN_W-1:0]);
  end

endmodule

// File: rtl/fp_cmp_pipe.sv
// Pipelined IEEE-754 comparator with run-time relation select, sideband tag
// and a single global advance enable driven by output backpressure.
module fp_cmp_pipe
  import sz_fp_pkg::*;
#(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   dataa,
  input  logic [EXP_W+MAN_W:0]   datab,
  input  logic [2:0]             mode,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   result,
  output logic                   a_lt_b,
  output logic                   a_eq_b,
  output logic                   unordered,
  output logic [TAG_W-1:0]       out_tag
);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("fp_cmp_pipe: LATENCY must be in 1..4");
  end
  if (EXP_W + MAN_W > MAG_MAX_W) begin : g_bad_width
    $error("fp_cmp_pipe: EXP_W+MAN_W exceeds supported magnitude width");
  end

  // Stage 2 and any trailing delay stages form one output chain.
  localparam int NO = (LATENCY == 1) ? 1 : LATENCY - 1;

  logic                en_s;
  logic                accept_s;
  fp_class_t           cls_a_s;
  fp_class_t           cls_b_s;
  cmp_s1_t             s1_d;
  cmp_s1_t             s1_s;
  logic                s1_valid_s;
  logic [TAG_W-1:0]    s1_tag_s;

  logic [NO-1:0]       vld_q;
  cmp_flags_t          flg_q [NO];
  logic [TAG_W-1:0]    tag_q [NO];

  assign en_s     = !out_valid || out_ready;
  assign in_ready = en_s && !reset;
  assign accept_s = in_valid && in_ready;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .op_i  (dataa),
    .cls_o (cls_a_s)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .op_i  (datab),
    .cls_o (cls_b_s)
  );

  always_comb begin
    s1_d.sign_a    = cls_a_s.sign;
    s1_d.sign_b    = cls_b_s.sign;
    s1_d.any_nan   = cls_a_s.nan || cls_b_s.nan;
    s1_d.both_zero = cls_a_s.zero && cls_b_s.zero;
    s1_d.mag_lt    = cls_a_s.mag < cls_b_s.mag;
    s1_d.mag_gt    = cls_a_s.mag > cls_b_s.mag;
    s1_d.mode      = cmp_mode_e'(mode);
  end

  if (LATENCY == 1) begin : g_merged
    assign s1_s       = s1_d;
    assign s1_valid_s = accept_s;
    assign s1_tag_s   = in_tag;
  end else begin : g_stage1
    logic             s1_valid_q;
    cmp_s1_t          s1_q;
    logic [TAG_W-1:0] s1_tag_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        s1_valid_q <= 1'b0;
        s1_q       <= '0;
        s1_tag_q   <= '0;
      end else if (en_s) begin
        s1_valid_q <= accept_s;
        s1_q       <= s1_d;
        s1_tag_q   <= in_tag;
      end
    end

    assign s1_s       = s1_q;
    assign s1_valid_s = s1_valid_q;
    assign s1_tag_s   = s1_tag_q;
  end

  // Resolve into the first output slot; later slots are plain delays.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NO; i++) begin
        vld_q[i] <= 1'b0;
        flg_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (en_s) begin
      vld_q[0] <= s1_valid_s;
      flg_q[0] <= cmp_resolve(s1_s);
      tag_q[0] <= s1_tag_s;
      for (int i = 1; i < NO; i++) begin
        vld_q[i] <= vld_q[i-1];
        flg_q[i] <= flg_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[NO-1];
  assign result    = flg_q[NO-1].result;
  assign a_lt_b    = flg_q[NO-1].lt;
  assign a_eq_b    = flg_q[NO-1].eq;
  assign unordered = flg_q[NO-1].un;
  assign out_tag   = tag_q[NO-1];

endmodule
